// File: rtl/seq_multiplier_n_if.sv
// Handshake/operand bundle for seq_multiplier_n: control and operand inputs
// from the master, product registers and status from the multiplier.
interface seq_multiplier_n_if #(
    parameter int WIDTH = 8
) ();
    logic             load_b;
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] aval;
    logic [WIDTH-1:0] bval;
    logic             x;
    logic             busy;
    logic             done;

    modport master (
        output load_b, start, signed_op, din,
        input  aval, bval, x, busy, done
    );

    modport slave (
        input  load_b, start, signed_op, din,
        output aval, bval, x, busy, done
    );
endinterface

// File: rtl/seq_multiplier_n.sv
// Sequential shift-add multiplier producing a 2*WIDTH-bit product in {A,B}.
// Define MULT_SIGNED_EN to add two's-complement support (subtract on the last step).
module seq_multiplier_n #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    seq_multiplier_n_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        WAIT = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [WIDTH-1:0] a, a_n;
    logic [WIDTH-1:0] b, b_n;
    logic [WIDTH-1:0] s, s_n;
    logic            x, x_n;
    logic            mode, mode_n;
    logic [CW-1:0]   count, count_n;
    logic [WIDTH:0]  sum;

`ifdef MULT_SIGNED_EN
    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] s_ext;

    // Sign-extend both operands in signed mode so the WIDTH+1-bit sum never overflows.
    always_comb begin
        a_ext = {mode & a[WIDTH-1], a};
        s_ext = {mode & s[WIDTH-1], s};
        sum   = a_ext;
        if (b[0]) begin
            if (mode && (count == LAST)) sum = a_ext - s_ext;
            else                         sum = a_ext + s_ext;
        end
    end

    assign mode_n = (state == IDLE && !bus.load_b && bus.start) ? bus.signed_op : mode;
`else
    logic unused_signed;

    always_comb begin
        sum = {1'b0, a};
        if (b[0]) sum = {1'b0, a} + {1'b0, s};
    end

    assign mode_n        = 1'b0;
    assign unused_signed = bus.signed_op ^ mode;
`endif

    // NOTE: every next-state variable gets its hold value first so no path infers a latch.
    always_comb begin
        state_n = state;
        a_n     = a;
        b_n     = b;
        s_n     = s;
        x_n     = x;
        count_n = count;

        unique case (state)
            IDLE: begin
                if (bus.load_b) begin
                    b_n = bus.din;
                    a_n = '0;
                    x_n = 1'b0;
                end else if (bus.start) begin
                    s_n     = bus.din;
                    a_n     = '0;
                    x_n     = 1'b0;
                    count_n = '0;
                    state_n = RUN;
                end
            end
            RUN: begin
                x_n     = sum[WIDTH];
                a_n     = sum[WIDTH:1];
                b_n     = {sum[0], b[WIDTH-1:1]};
                count_n = count + 1'b1;
                if (count == LAST) state_n = DONE;
            end
            DONE: state_n = WAIT;
            WAIT: if (!bus.start) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all updates land together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            s     <= '0;
            x     <= 1'b0;
            mode  <= 1'b0;
            count <= '0;
        end else begin
            state <= state_n;
            a     <= a_n;
            b     <= b_n;
            s     <= s_n;
            x     <= x_n;
            mode  <= mode_n;
            count <= count_n;
        end
    end

    assign bus.aval = a;
    assign bus.bval = b;
    assign bus.x    = x;
    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);

endmodule

// File: tb/tb_seq_multiplier_n.sv
// Scoreboard bench for seq_multiplier_n: WIDTH=8 and WIDTH=16 instances, directed vectors.
module tb_seq_multiplier_n;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_multiplier_n_if #(.WIDTH(8))  bus8 ();
    seq_multiplier_n_if #(.WIDTH(16)) bus16 ();

    seq_multiplier_n #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
    seq_multiplier_n #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

    typedef struct {
        logic [63:0] prod;
        int          start_cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    exp_t e8, e16;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

`ifdef MULT_SIGNED_EN
    localparam logic [15:0] EXP_FF_03 = 16'hFFFD;
    localparam logic [31:0] EXP_W16   = 32'hC000_8000;
`else
    localparam logic [15:0] EXP_FF_03 = 16'h02FD;
    localparam logic [31:0] EXP_W16   = 32'h3FFF_8000;
`endif

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: every Done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus8.done === 1'b1) begin
            if (q8.size() == 0) check("dut8 unexpected done", 1, 0);
            else begin
                e8 = q8.pop_front();
                check("dut8 product", {bus8.aval, bus8.bval}, e8.prod);
                check("dut8 done latency", 64'(cyc - e8.start_cyc), 9);
            end
        end
        if (bus16.done === 1'b1) begin
            if (q16.size() == 0) check("dut16 unexpected done", 1, 0);
            else begin
                e16 = q16.pop_front();
                check("dut16 product", {bus16.aval, bus16.bval}, e16.prod);
                check("dut16 done latency", 64'(cyc - e16.start_cyc), 17);
            end
        end
    end

    task automatic load8(input logic [7:0] bv);
        @(negedge clk);
        bus8.din    = bv;
        bus8.load_b = 1'b1;
        @(negedge clk);
        bus8.load_b = 1'b0;
        check("dut8 load B", {bus8.aval, bus8.bval, bus8.busy}, {8'h00, bv, 1'b0});
    endtask

    // Start a multiply, optionally scrambling Din/Load_B during RUN, hold Start
    // for 'hold' cycles after Done, then release and confirm the return to IDLE.
    task automatic start8(input logic [7:0] sv, input logic sg, input logic [15:0] exp,
                          input bit scramble, input int hold);
        int n;
        @(negedge clk);
        bus8.din       = sv;
        bus8.signed_op = sg;
        bus8.start     = 1'b1;
        q8.push_back('{prod: 64'(exp), start_cyc: cyc});
        @(negedge clk);
        n = 0;
        while (bus8.done !== 1'b1 && n < 40) begin
            if (scramble) begin
                bus8.din    = 8'($urandom);
                bus8.load_b = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            n++;
        end
        bus8.load_b = 1'b0;
        check("dut8 done seen", bus8.done, 1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("dut8 wait hold", {bus8.busy, bus8.x, bus8.aval, bus8.bval},
                  {1'b1, exp[15], exp});
        end
        bus8.start = 1'b0;
        @(negedge clk);
        check("dut8 idle after start low", bus8.busy, 0);
    endtask

    initial begin
        int n;
        rst             = 1'b1;
        bus8.load_b     = 1'b0;
        bus8.start      = 1'b0;
        bus8.signed_op  = 1'b0;
        bus8.din        = '0;
        bus16.load_b    = 1'b0;
        bus16.start     = 1'b0;
        bus16.signed_op = 1'b0;
        bus16.din       = '0;
        #12;
        check("reset outputs", {bus8.aval, bus8.bval, bus8.x, bus8.busy, bus8.done}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Unsigned full-scale, signed mixed, most-negative squared, latch/stability.
        load8(8'hFF); start8(8'hFF, 1'b0, 16'hFE01, 1'b0, 2);
        load8(8'hFF); start8(8'h03, 1'b1, EXP_FF_03, 1'b0, 1);
        load8(8'h80); start8(8'h80, 1'b1, 16'h4000, 1'b0, 1);
        load8(8'h07); start8(8'h03, 1'b0, 16'h0015, 1'b1, 3);

        // Load_B wins over Start in IDLE.
        @(negedge clk);
        bus8.din    = 8'h05;
        bus8.load_b = 1'b1;
        bus8.start  = 1'b1;
        @(negedge clk);
        bus8.load_b = 1'b0;
        bus8.start  = 1'b0;
        check("priority stays idle", {bus8.busy, bus8.bval}, {1'b0, 8'h05});
        start8(8'h03, 1'b0, 16'h000F, 1'b0, 1);

        // Abort three cycles into RUN: outputs clear at once, no Done.
        load8(8'h09);
        @(negedge clk);
        bus8.din   = 8'h09;
        bus8.start = 1'b1;
        repeat (4) @(negedge clk);
        check("abort still busy", bus8.busy, 1);
        rst = 1'b1;
        #1;
        check("abort outputs cleared", {bus8.aval, bus8.bval, bus8.x, bus8.busy, bus8.done}, 0);
        @(negedge clk);
        bus8.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        load8(8'h02); start8(8'h02, 1'b0, 16'h0004, 1'b0, 1);

        // Wide operands on the 16-bit instance.
        @(negedge clk);
        bus16.din    = 16'h8000;
        bus16.load_b = 1'b1;
        @(negedge clk);
        bus16.load_b    = 1'b0;
        bus16.din       = 16'h7FFF;
        bus16.signed_op = 1'b1;
        bus16.start     = 1'b1;
        q16.push_back('{prod: 64'(EXP_W16), start_cyc: cyc});
        @(negedge clk);
        n = 0;
        while (bus16.done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("dut16 done seen", bus16.done, 1);
        @(negedge clk);
        check("dut16 wait busy", bus16.busy, 1);
        bus16.start = 1'b0;
        @(negedge clk);
        check("dut16 idle after start low", bus16.busy, 0);

        repeat (3) @(negedge clk);
        check("dut8 scoreboard drained", 64'(q8.size()), 0);
        check("dut16 scoreboard drained", 64'(q16.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
